osc_clk_gate_ctrl: RTL and testbench
====================================

OSC_CLK_GATE_CTRL -- requirements
Module: osc_clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of gated clock consumers (1..32).
REQ-002 The block SHALL have parameter STAB_W, default 16, giving the width of the oscillator stabilisation counter.
REQ-003 The block SHALL have parameter HOLD_W, default 8, giving the width of the power-down hold-off counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock) and rst_b input 1 (async active-low reset).
REQ-005 The ports SHALL be: stab_cycles input STAB_W (stabilisation delay); hold_cycles input HOLD_W (hold-off delay); ch_req input NUM_CH (per-channel clock request); ch_ack output NUM_CH (per-channel clock enable/grant, drives gate CE); osc_en output 1 (oscillator pad enable); osc_ready output 1 (oscillator stable); fsm_state output 2 (debug state).

Function
REQ-006 The FSM SHALL have states OFF=0, STARTUP=1, RUN=2, HOLDOFF=3, and fsm_state SHALL equal the registered state.
REQ-007 In OFF, if |ch_req, the FSM SHALL move to STARTUP next cycle and load cnt=stab_cycles; otherwise it SHALL stay in OFF.
REQ-008 In STARTUP, if cnt==0 the FSM SHALL move to RUN, else cnt decrements; STARTUP SHALL last exactly stab_cycles+1 cycles regardless of ch_req (no abort).
REQ-009 In RUN, if ch_req==0 the FSM SHALL move to HOLDOFF and load cnt=hold_cycles; otherwise it SHALL stay in RUN.
REQ-010 In HOLDOFF, |ch_req SHALL return the FSM to RUN next cycle without restart; else if cnt==0 it SHALL move to OFF, else cnt decrements.
REQ-011 stab_cycles and hold_cycles SHALL be sampled only at counter load; changes mid-count SHALL have no effect.
REQ-012 osc_en SHALL be a registered output, 1 in STARTUP, RUN and HOLDOFF, and 0 in OFF.
REQ-013 osc_ready SHALL be a registered output, 1 exactly when state is RUN or HOLDOFF.
REQ-014 ch_ack[i] SHALL be registered: ch_ack[i] <= ch_req[i] & (state==RUN), giving a one-cycle req-to-ack latency while in RUN.
REQ-015 ch_ack SHALL be all-zero in OFF, STARTUP and HOLDOFF, and only registered outputs SHALL drive ch_ack and osc_en (glitch-free CE).
REQ-016 A channel deasserting ch_req in RUN SHALL see ch_ack fall on the next cycle while other channels are unaffected.
REQ-017 Simultaneous req rise on several channels SHALL produce simultaneous ack rise.
REQ-018 With stab_cycles=0, STARTUP SHALL last 1 cycle; with hold_cycles=0, HOLDOFF SHALL last 1 cycle.
REQ-019 The counter width SHALL be max(STAB_W, HOLD_W), and the counter SHALL never wrap below 0.

Reset
REQ-020 While rst_b=0, the block SHALL asynchronously hold state=OFF, cnt=0, osc_en=0, osc_ready=0 and ch_ack=0.
REQ-021 Reset asserted mid-STARTUP or mid-RUN SHALL drop osc_en and ch_ack immediately, and after release the FSM SHALL restart from OFF.
REQ-022 The first state transition SHALL occur no earlier than the first rising clk edge after rst_b deasserts.

Structure
REQ-023 The state encoding (OFF/STARTUP/RUN/HOLDOFF) and the parameter defaults SHALL live in shared package osc_ctrl_pkg.
REQ-024 The loadable down-counter with a zero flag SHALL be the sub-module osc_ctrl_cnt (ports: clk, rst_b, load, load_val, dec, cnt_zero).
REQ-025 The FSM and the ack registers SHALL be in osc_clk_gate_ctrl, and no clock-path cells SHALL be instantiated in the block.

Verification
REQ-026 Cold start: with stab_cycles=5, raise ch_req[0] at cycle 0 -> osc_en=1 at cycle 1, RUN at cycle 7, ch_ack[0]=1 at cycle 8.
REQ-027 Hold-off rescue: in RUN with hold_cycles=3, drop all req, then raise ch_req[2] 2 cycles later -> HOLDOFF->RUN, osc_en stays 1, ch_ack[2] rises 2 cycles after the request.
REQ-028 Power-down: in RUN with hold_cycles=3, drop all req -> HOLDOFF lasts 4 cycles, then OFF, osc_en=0, osc_ready=0.
REQ-029 Request during STARTUP: with stab_cycles=4, pulse ch_req[1] for 2 cycles then drop -> STARTUP completes (5 cycles), RUN, then HOLDOFF, and ch_ack stays 0 throughout.
REQ-030 Async reset: assert rst_b=0 mid-RUN with ch_ack=4'b1011 -> ch_ack=0, osc_en=0 and fsm_state=0 without any clk edge.
REQ-031 Zero delays: with stab_cycles=0 and hold_cycles=0, raise all 4 reqs -> ack=4'hF at cycle 3; drop all reqs -> OFF 2 cycles later.

Source files
------------

// File: rtl/osc_ctrl_pkg.sv
// Shared definitions for the oscillator clock-gate controller: FSM state
// encoding, parameter defaults and the counter width helper.
package osc_ctrl_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int STAB_W_DEF = 16;
    localparam int HOLD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_STARTUP = 2'd1,
        ST_RUN     = 2'd2,
        ST_HOLDOFF = 2'd3
    } osc_state_e;

    // Shared counter serves both delays, so it must hold the wider of the two.
    function automatic int cnt_width(input int stab_w, input int hold_w);
        return (stab_w > hold_w) ? stab_w : hold_w;
    endfunction

endpackage

// File: rtl/osc_ctrl_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module osc_ctrl_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             cnt_zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority, decrement only while non-zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/osc_clk_gate_ctrl.sv
// Oscillator power sequencer with per-channel clock-enable grants. All
// outputs that reach clock-gate CE pins come straight from flops.
module osc_clk_gate_ctrl #(
    parameter int NUM_CH = osc_ctrl_pkg::NUM_CH_DEF,
    parameter int STAB_W = osc_ctrl_pkg::STAB_W_DEF,
    parameter int HOLD_W = osc_ctrl_pkg::HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [STAB_W-1:0] stab_cycles,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_ack,
    output logic              osc_en,
    output logic              osc_ready,
    output logic [1:0]        fsm_state
);

    import osc_ctrl_pkg::*;

    localparam int CNT_W = cnt_width(STAB_W, HOLD_W);

    osc_state_e        state_q;
    osc_state_e        state_d;
    logic              cnt_load_s;
    logic [CNT_W-1:0]  cnt_load_val_s;
    logic              cnt_dec_s;
    logic              cnt_zero_s;
    logic [NUM_CH-1:0] ch_ack_q;
    logic [NUM_CH-1:0] ch_ack_d;
    logic              osc_en_q;
    logic              osc_en_d;
    logic              osc_ready_q;
    logic              osc_ready_d;

    osc_ctrl_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .cnt_zero (cnt_zero_s)
    );

    // Next-state and counter control
    always_comb begin
        state_d        = state_q;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CNT_W{1'b0}};
        cnt_dec_s      = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (|ch_req) begin
                    state_d        = ST_STARTUP;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CNT_W'(stab_cycles);
                end else begin
                    state_d = ST_OFF;
                end
            end
            // Startup always runs to completion so the oscillator is never
            // left half-stabilised.
            ST_STARTUP: begin
                if (cnt_zero_s) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (ch_req == {NUM_CH{1'b0}}) begin
                    state_d        = ST_HOLDOFF;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CNT_W'(hold_cycles);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLDOFF: begin
                if (|ch_req) begin
                    state_d = ST_RUN;
                end else if (cnt_zero_s) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Output flops are fed from the next state so they line up with state_q
    always_comb begin
        osc_en_d    = (state_d != ST_OFF);
        osc_ready_d = (state_d == ST_RUN) || (state_d == ST_HOLDOFF);
        if (state_q == ST_RUN) begin
            ch_ack_d = ch_req;
        end else begin
            ch_ack_d = {NUM_CH{1'b0}};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_OFF;
            osc_en_q    <= 1'b0;
            osc_ready_q <= 1'b0;
            ch_ack_q    <= {NUM_CH{1'b0}};
        end else begin
            state_q     <= state_d;
            osc_en_q    <= osc_en_d;
            osc_ready_q <= osc_ready_d;
            ch_ack_q    <= ch_ack_d;
        end
    end

    assign fsm_state = state_q;
    assign osc_en    = osc_en_q;
    assign osc_ready = osc_ready_q;
    assign ch_ack    = ch_ack_q;

endmodule

// File: tb/tb_osc_clk_gate_ctrl.sv
// Directed bench for osc_clk_gate_ctrl with hand-computed expectations.
module tb_osc_clk_gate_ctrl;

    logic        clk;
    logic        rst_b;
    logic [15:0] stab_cycles;
    logic [7:0]  hold_cycles;
    logic [3:0]  ch_req;
    logic [3:0]  ch_ack;
    logic        osc_en;
    logic        osc_ready;
    logic [1:0]  fsm_state;

    int err_cnt = 0;
    int chk_cnt = 0;

    osc_clk_gate_ctrl #(
        .NUM_CH (4),
        .STAB_W (16),
        .HOLD_W (8)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .stab_cycles (stab_cycles),
        .hold_cycles (hold_cycles),
        .ch_req      (ch_req),
        .ch_ack      (ch_ack),
        .osc_en      (osc_en),
        .osc_ready   (osc_ready),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic en,
                              input logic rdy, input logic [3:0] ack);
        check_eq({tag, ".state"}, {30'd0, fsm_state}, {30'd0, st});
        check_eq({tag, ".osc_en"}, {31'd0, osc_en}, {31'd0, en});
        check_eq({tag, ".osc_ready"}, {31'd0, osc_ready}, {31'd0, rdy});
        check_eq({tag, ".ack"}, {28'd0, ch_ack}, {28'd0, ack});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_b       = 1'b0;
        ch_req      = 4'h0;
        stab_cycles = 16'd5;
        hold_cycles = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 2'd0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst_b = 1'b1;
        step();
        check_outs("idle", 2'd0, 1'b0, 1'b0, 4'h0);

        // Cold start, stab=5; mid-count change of stab_cycles must be ignored
        ch_req = 4'b0001;
        step();
        check_outs("cold.c1", 2'd1, 1'b1, 1'b0, 4'h0);
        stab_cycles = 16'd1;
        repeat (5) step();
        check_outs("cold.c6", 2'd1, 1'b1, 1'b0, 4'h0);
        step();
        check_outs("cold.c7", 2'd2, 1'b1, 1'b1, 4'h0);
        step();
        check_outs("cold.c8", 2'd2, 1'b1, 1'b1, 4'b0001);

        ch_req = 4'b1011;
        step();
        check_outs("multi.rise", 2'd2, 1'b1, 1'b1, 4'b1011);
        ch_req = 4'b1010;
        step();
        check_outs("single.fall", 2'd2, 1'b1, 1'b1, 4'b1010);

        // Hold-off rescue, hold=3
        hold_cycles = 8'd3;
        ch_req = 4'h0;
        step();
        check_outs("rescue.h1", 2'd3, 1'b1, 1'b1, 4'h0);
        step();
        check_outs("rescue.h2", 2'd3, 1'b1, 1'b1, 4'h0);
        ch_req = 4'b0100;
        step();
        check_outs("rescue.run", 2'd2, 1'b1, 1'b1, 4'h0);
        step();
        check_outs("rescue.ack", 2'd2, 1'b1, 1'b1, 4'b0100);

        // Power-down: hold-off of 4 cycles; hold_cycles change after load ignored
        ch_req = 4'h0;
        step();
        hold_cycles = 8'd0;
        for (int i = 0; i < 4; i++) begin
            check_outs("pdown.hold", 2'd3, 1'b1, 1'b1, 4'h0);
            if (i < 3) step();
        end
        step();
        check_outs("pdown.off", 2'd0, 1'b0, 1'b0, 4'h0);

        // Request pulse during startup, stab=4
        stab_cycles = 16'd4;
        hold_cycles = 8'd3;
        ch_req = 4'b0010;
        step();
        step();
        ch_req = 4'h0;
        for (int i = 2; i <= 5; i++) begin
            check_outs("pulse.startup", 2'd1, 1'b1, 1'b0, 4'h0);
            step();
        end
        check_outs("pulse.run", 2'd2, 1'b1, 1'b1, 4'h0);
        step();
        check_outs("pulse.hold", 2'd3, 1'b1, 1'b1, 4'h0);
        repeat (4) step();
        check_outs("pulse.off", 2'd0, 1'b0, 1'b0, 4'h0);

        // Async reset mid-RUN with ack=1011
        stab_cycles = 16'd0;
        hold_cycles = 8'd0;
        ch_req = 4'b1011;
        step();
        step();
        step();
        check_outs("arst.pre", 2'd2, 1'b1, 1'b1, 4'b1011);
        #2;
        rst_b = 1'b0;
        #1;
        check_outs("arst.async", 2'd0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check_outs("arst.release", 2'd0, 1'b0, 1'b0, 4'h0);
        step();
        check_outs("arst.first_edge", 2'd1, 1'b1, 1'b0, 4'h0);
        ch_req = 4'h0;
        step();
        step();
        step();
        check_outs("arst.off", 2'd0, 1'b0, 1'b0, 4'h0);

        // Zero delays: ack at cycle 3, OFF two cycles after drop
        ch_req = 4'hF;
        step();
        check_outs("zero.c1", 2'd1, 1'b1, 1'b0, 4'h0);
        step();
        check_outs("zero.c2", 2'd2, 1'b1, 1'b1, 4'h0);
        step();
        check_outs("zero.c3", 2'd2, 1'b1, 1'b1, 4'hF);
        ch_req = 4'h0;
        step();
        check_outs("zero.hold", 2'd3, 1'b1, 1'b1, 4'h0);
        step();
        check_outs("zero.off", 2'd0, 1'b0, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
